// File: rtl/cam_cmd_initiator_if.sv
// cam_cmd_initiator_if: the bundle of signals around the CAM command initiator.
// It carries the command request, the byte stream to the interpreter, the reply
// byte stream from the interpreter, and the completion response.
// The master modport is the initiator's side. The slave modport is the side that
// issues commands and models the interpreter.
interface cam_cmd_initiator_if #(
    parameter int DATA_W = 32
);
    // Command request
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;

    // Byte stream to the interpreter
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    // Reply byte stream from the interpreter
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;

    // Completion response
    logic              rsp_valid;
    logic [2:0]        rsp_status;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, tx_ready, rx_data, rx_valid,
        output cmd_ready, tx_data, tx_valid, rx_ready,
               rsp_valid, rsp_status, rsp_data, busy
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, tx_ready, rx_data, rx_valid,
        input  cmd_ready, tx_data, tx_valid, rx_ready,
               rsp_valid, rsp_status, rsp_data, busy
    );
endinterface

// File: rtl/cam_cmd_initiator.sv
// cam_cmd_initiator: the command-issuing end of the ASCII CAM control protocol.
//
// The block takes one CAM operation and serialises it into command bytes:
//   opcode char, CR, [payload bytes, CR]
// For get operations it then parses the "value CR LF" reply into a word.
//
// Optional statistics counters are built when the macro
// CAM_CMD_INITIATOR_STATS_EN is defined. That adds the ports stat_cmds,
// stat_errs and stat_drops. Without the macro those ports and their counters
// are absent.
module cam_cmd_initiator #(
    parameter int DATA_W         = 32,
    parameter int TAG_W          = 16,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4800
) (
    input  logic                 clk_48mhz,
    input  logic                 reset_n,
    cam_cmd_initiator_if.master  bus
`ifdef CAM_CMD_INITIATOR_STATS_EN
    ,
    output logic [15:0]          stat_cmds,
    output logic [15:0]          stat_errs,
    output logic [15:0]          stat_drops
`endif
);

    // Operation codes
    localparam logic [3:0] OP_SET_COMPARAND = 4'd0;
    localparam logic [3:0] OP_GET_COMPARAND = 4'd1;
    localparam logic [3:0] OP_SET_MASK      = 4'd2;
    localparam logic [3:0] OP_GET_MASK      = 4'd3;
    localparam logic [3:0] OP_GET_TAGS      = 4'd5;
    localparam logic [3:0] OP_READ          = 4'd9;
    localparam logic [3:0] OP_LAST_LEGAL    = 4'd10;

    // Protocol characters
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_A  = 8'h61;

    // Byte counts and counter widths.
    // At most 16 payload bytes plus 2 terminators, so 5 bits cover every position.
    localparam logic [4:0] DATA_BYTES = 5'(DATA_W / 8);
    localparam logic [4:0] TAG_BYTES  = 5'(TAG_W / 8);
    localparam logic [4:0] PAY_LAST   = 5'(DATA_W / 8 - 1);
    localparam int         GAP_W      = $clog2(GAP_CYCLES + 1);
    localparam int         TO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_SEND_OP,
        S_SEND_CR1,
        S_SEND_PAY,
        S_SEND_CR2,
        S_GAP,
        S_RECV,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        ST_OK          = 3'd0,
        ST_ILLEGAL_OP  = 3'd1,
        ST_BAD_PAYLOAD = 3'd2,
        ST_TIMEOUT     = 3'd3,
        ST_FRAMING     = 3'd4
    } status_t;

    state_t            state_q, state_d;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] data_q;
    logic [4:0]        idx_q;
    logic [GAP_W-1:0]  gap_q;
    logic [TO_W-1:0]   to_q;
    logic [DATA_W-1:0] rx_shift_q;
    status_t           status_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rx_ready_q;

    logic              op_legal;
    logic              op_is_set;
    logic              op_is_get;
    logic              pay_bad;
    logic [4:0]        reply_bytes;
    logic              tx_fire;
    logic              rx_take;

    // Decode the latched operation and screen the payload for forbidden bytes
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        op_legal    = (op_q <= OP_LAST_LEGAL);
        op_is_set   = (op_q == OP_SET_COMPARAND) || (op_q == OP_SET_MASK);
        op_is_get   = (op_q == OP_GET_COMPARAND) || (op_q == OP_GET_MASK) ||
                      (op_q == OP_GET_TAGS)      || (op_q == OP_READ);
        reply_bytes = (op_q == OP_GET_TAGS) ? TAG_BYTES : DATA_BYTES;
        pay_bad     = 1'b0;
        for (int i = 0; i < DATA_W / 8; i++) begin
            if ((data_q[i*8 +: 8] == CHAR_CR) || data_q[i*8 + 7]) begin
                pay_bad = 1'b1;
            end
        end
    end

    assign tx_fire = bus.tx_valid & bus.tx_ready;
    assign rx_take = bus.rx_valid & rx_ready_q & (state_q == S_RECV);

    // State register
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and transmit-side outputs
    always_comb begin
        state_d      = state_q;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (!op_legal || (op_is_set && pay_bad)) state_d = S_DONE;
                else                                     state_d = S_SEND_OP;
            end
            S_SEND_OP: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = CHAR_A + {4'b0000, op_q};
                if (bus.tx_ready) state_d = S_SEND_CR1;
            end
            S_SEND_CR1: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = CHAR_CR;
                if (bus.tx_ready) begin
                    if (op_is_set)      state_d = S_SEND_PAY;
                    else if (op_is_get) state_d = S_RECV;
                    else                state_d = S_GAP;
                end
            end
            S_SEND_PAY: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = data_q[idx_q*8 +: 8];
                if (bus.tx_ready && (idx_q == PAY_LAST)) state_d = S_SEND_CR2;
            end
            S_SEND_CR2: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = CHAR_CR;
                if (bus.tx_ready) state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = S_DONE;
            end
            S_RECV: begin
                if (rx_take) begin
                    if ((idx_q == reply_bytes) && (bus.rx_data != CHAR_CR)) state_d = S_DONE;
                    else if (idx_q == reply_bytes + 5'd1)                   state_d = S_DONE;
                end else if (to_q == TO_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath: latch the command, step byte/gap/timeout counters, assemble the reply
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            op_q       <= 4'd0;
            data_q     <= '0;
            idx_q      <= 5'd0;
            gap_q      <= '0;
            to_q       <= '0;
            rx_shift_q <= '0;
            status_q   <= ST_OK;
            rsp_data_q <= '0;
            rx_ready_q <= 1'b0;
        end else begin
            rx_ready_q <= 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q       <= bus.cmd_op;
                        data_q     <= bus.cmd_data;
                        idx_q      <= 5'd0;
                        gap_q      <= '0;
                        to_q       <= '0;
                        rx_shift_q <= '0;
                        status_q   <= ST_OK;
                        rsp_data_q <= '0;
                    end
                end
                S_CHECK: begin
                    if (!op_legal)                  status_q <= ST_ILLEGAL_OP;
                    else if (op_is_set && pay_bad)  status_q <= ST_BAD_PAYLOAD;
                end
                S_SEND_PAY: begin
                    if (tx_fire) idx_q <= idx_q + 5'd1;
                end
                S_GAP: begin
                    gap_q <= gap_q + GAP_W'(1);
                end
                S_RECV: begin
                    if (rx_take) begin
                        to_q  <= '0;
                        idx_q <= idx_q + 5'd1;
                        if (idx_q < reply_bytes) begin
                            // Value bytes arrive most significant first
                            rx_shift_q <= (rx_shift_q << 8) | DATA_W'(bus.rx_data);
                        end else if (idx_q == reply_bytes) begin
                            if (bus.rx_data != CHAR_CR) status_q <= ST_FRAMING;
                        end else begin
                            if (bus.rx_data != CHAR_LF) status_q   <= ST_FRAMING;
                            else                        rsp_data_q <= rx_shift_q;
                        end
                    end else if (to_q == TO_LAST) begin
                        status_q <= ST_TIMEOUT;
                    end else begin
                        to_q <= to_q + TO_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.cmd_ready  = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.rsp_valid  = (state_q == S_DONE);
    assign bus.rsp_status = status_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rx_ready   = rx_ready_q;

`ifdef CAM_CMD_INITIATOR_STATS_EN
    // Saturating counters of completions, error completions and dropped reply bytes
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            stat_cmds  <= 16'd0;
            stat_errs  <= 16'd0;
            stat_drops <= 16'd0;
        end else begin
            if (bus.rsp_valid && (stat_cmds != 16'hFFFF)) begin
                stat_cmds <= stat_cmds + 16'd1;
            end
            if (bus.rsp_valid && (status_q != ST_OK) && (stat_errs != 16'hFFFF)) begin
                stat_errs <= stat_errs + 16'd1;
            end
            if (bus.rx_valid && rx_ready_q && (state_q != S_RECV) && (stat_drops != 16'hFFFF)) begin
                stat_drops <= stat_drops + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cam_cmd_initiator.sv
// tb_cam_cmd_initiator: directed, scoreboard-checked bench for cam_cmd_initiator.
// Each test pushes the expected transmit bytes and response into queues.
// Independent monitors pop those queues and compare against what the design
// presents.
module tb_cam_cmd_initiator;

    localparam int DATA_W  = 32;
    localparam int TAG_W   = 16;
    localparam int GAP     = 16;
    localparam int TIMEOUT = 4800;

    typedef struct {
        logic [2:0]  status;
        logic [31:0] data;
    } rsp_t;

    logic clk_48mhz = 1'b0;
    logic reset_n   = 1'b0;

    always #10 clk_48mhz = ~clk_48mhz;

    cam_cmd_initiator_if #(.DATA_W(DATA_W)) bus ();

`ifdef CAM_CMD_INITIATOR_STATS_EN
    logic [15:0] stat_cmds, stat_errs, stat_drops;
`endif

    cam_cmd_initiator #(
        .DATA_W(DATA_W), .TAG_W(TAG_W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_48mhz (clk_48mhz),
        .reset_n   (reset_n),
        .bus       (bus)
`ifdef CAM_CMD_INITIATOR_STATS_EN
        ,
        .stat_cmds (stat_cmds),
        .stat_errs (stat_errs),
        .stat_drops(stat_drops)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_tx[$];
    rsp_t       exp_rsp[$];

    int cyc          = 0;
    int accept_cyc   = 0;
    int first_tx_cyc = -1;
    int last_tx_cyc  = 0;
    int rsp_cyc      = 0;
    int take_cyc     = 0;
    int tx_seen      = 0;
    int hold_checks  = 0;
    int tx_mode      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_48mhz) cyc++;

    // tx_ready driver: always ready, or toggling every cycle to force stalls
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk_48mhz);
            #1;
            bus.tx_ready = (tx_mode == 0) ? 1'b1 : ~bus.tx_ready;
        end
    end

    // Transmit monitor: byte order, first-byte latency, stall stability
    logic       stall_pending = 1'b0;
    logic [7:0] stall_byte    = 8'h00;
    always @(negedge clk_48mhz) begin
        if (!reset_n) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                check("tx_valid_hold", bus.tx_valid, 1'b1);
                check("tx_data_hold", bus.tx_data, stall_byte);
                hold_checks++;
            end
            stall_pending = 1'b0;
            if (bus.tx_valid) begin
                tx_seen++;
                if (first_tx_cyc < 0) first_tx_cyc = cyc;
                if (bus.tx_ready) begin
                    last_tx_cyc = cyc + 1;
                    if (exp_tx.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL tx_extra: got 0x%0h, expected no byte", bus.tx_data);
                    end else begin
                        check("tx_byte", bus.tx_data, exp_tx.pop_front());
                    end
                end else begin
                    stall_pending = 1'b1;
                    stall_byte    = bus.tx_data;
                end
            end
        end
    end

    // Response monitor
    always @(negedge clk_48mhz) begin
        if (reset_n && bus.rsp_valid) begin
            rsp_t e;
            rsp_cyc = cyc;
            if (exp_rsp.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_extra: got status %0d, expected no response", bus.rsp_status);
            end else begin
                e = exp_rsp.pop_front();
                check("rsp_status", bus.rsp_status, e.status);
                check("rsp_data", bus.rsp_data, e.data);
            end
        end
    end

    task automatic push_tx(input logic [63:0] bytes, input int n);
        // bytes listed in send order, first byte in the most significant used position
        for (int i = 0; i < n; i++) exp_tx.push_back(bytes[8*(n-1-i) +: 8]);
    endtask

    task automatic push_rsp(input logic [2:0] st, input logic [31:0] d);
        rsp_t r;
        r.status = st;
        r.data   = d;
        exp_rsp.push_back(r);
    endtask

    task automatic do_cmd(input logic [3:0] op, input logic [31:0] data);
        logic ok;
        ok = 1'b0;
        first_tx_cyc = -1;
        @(posedge clk_48mhz);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_48mhz);
            if (bus.cmd_ready) begin
                accept_cyc = cyc;
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk_48mhz);
        #1;
        bus.cmd_valid = 1'b0;
        check("cmd_accepted", ok, 1'b1);
    endtask

    task automatic wait_tx_empty(input string name);
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk_48mhz);
            #1;
            if (exp_tx.size() == 0) break;
        end
        check(name, exp_tx.size(), 0);
        exp_tx.delete();
    endtask

    task automatic wait_rsp(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_48mhz);
            #1;
            if (exp_rsp.size() == 0) break;
        end
        check(name, exp_rsp.size(), 0);
        exp_rsp.delete();
    endtask

    task automatic send_reply(input logic [63:0] bytes, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_48mhz);
            #1;
            bus.rx_valid = 1'b1;
            bus.rx_data  = bytes[8*(n-1-i) +: 8];
            @(posedge clk_48mhz);
            #1;
            take_cyc     = cyc;
            bus.rx_valid = 1'b0;
        end
    endtask

    int tx_before;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'd0;
        bus.cmd_data  = '0;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;

        // Reset state
        repeat (3) @(negedge clk_48mhz);
        check("reset_tx_valid", bus.tx_valid, 1'b0);
        check("reset_tx_data", bus.tx_data, 8'h00);
        check("reset_rsp_valid", bus.rsp_valid, 1'b0);
        check("reset_rsp_status", bus.rsp_status, 3'd0);
        check("reset_rsp_data", bus.rsp_data, 32'd0);
        check("reset_busy", bus.busy, 1'b0);
        #3 reset_n = 1'b1;
        repeat (2) @(negedge clk_48mhz);
        check("rx_ready_after_reset", bus.rx_ready, 1'b1);
        check("cmd_ready_idle", bus.cmd_ready, 1'b1);

        // SET_COMPARAND: full byte stream, latency, gap timing
        push_tx(64'h61_0D_11_22_33_44_0D, 7);
        push_rsp(3'd0, 32'h0);
        do_cmd(4'd0, 32'h44332211);
        wait_rsp("set_cmp_rsp", 200);
        check("first_tx_latency", first_tx_cyc - accept_cyc, 2);
        check("gap_timing", rsp_cyc - last_tx_cyc, GAP);
        check("set_cmp_tx_drained", exp_tx.size(), 0);

        // GET_COMPARAND with tx_ready high
        push_tx(64'h62_0D, 2);
        push_rsp(3'd0, 32'h44332211);
        do_cmd(4'd1, 32'h0);
        wait_tx_empty("get_cmp_tx");
        send_reply(64'h44_33_22_11_0D_0A, 6);
        wait_rsp("get_cmp_rsp", 50);

        // GET_COMPARAND with tx_ready toggling
        tx_mode = 1;
        push_tx(64'h62_0D, 2);
        push_rsp(3'd0, 32'h44332211);
        do_cmd(4'd1, 32'h0);
        wait_tx_empty("get_cmp_stall_tx");
        send_reply(64'h44_33_22_11_0D_0A, 6);
        wait_rsp("get_cmp_stall_rsp", 50);
        check("stall_observed", hold_checks > 0, 1'b1);
        tx_mode = 0;
        repeat (2) @(posedge clk_48mhz);

        // GET_TAGS good reply, then a bad LF
        push_tx(64'h66_0D, 2);
        push_rsp(3'd0, 32'h0000A55A);
        do_cmd(4'd5, 32'h0);
        wait_tx_empty("get_tags_tx");
        send_reply(64'hA5_5A_0D_0A, 4);
        wait_rsp("get_tags_rsp", 50);

        push_tx(64'h66_0D, 2);
        push_rsp(3'd4, 32'h0);
        do_cmd(4'd5, 32'h0);
        wait_tx_empty("framing_tx");
        send_reply(64'hA5_5A_0D_41, 4);
        wait_rsp("framing_rsp", 50);

        // Illegal op: no bytes
        tx_before = tx_seen;
        push_rsp(3'd1, 32'h0);
        do_cmd(4'd12, 32'h0);
        wait_rsp("illegal_rsp", 50);
        check("illegal_no_tx", tx_seen - tx_before, 0);

        // Bad payloads: CR byte, byte with bit 7 set
        tx_before = tx_seen;
        push_rsp(3'd2, 32'h0);
        do_cmd(4'd2, 32'h00000D00);
        wait_rsp("bad_cr_rsp", 50);
        check("bad_cr_no_tx", tx_seen - tx_before, 0);

        tx_before = tx_seen;
        push_rsp(3'd2, 32'h0);
        do_cmd(4'd0, 32'h00800000);
        wait_rsp("bad_hi_rsp", 50);
        check("bad_hi_no_tx", tx_seen - tx_before, 0);

        // Payload just inside the legal range
        push_tx(64'h63_0D_01_0E_0C_7F_0D, 7);
        push_rsp(3'd0, 32'h0);
        do_cmd(4'd2, 32'h7F0C0E01);
        wait_rsp("edge_pay_rsp", 200);
        check("edge_pay_tx_drained", exp_tx.size(), 0);

        // READ with truncated reply
        push_tx(64'h6A_0D, 2);
        push_rsp(3'd3, 32'h0);
        do_cmd(4'd9, 32'h0);
        wait_tx_empty("timeout_tx");
        send_reply(64'h12_34, 2);
        wait_rsp("timeout_rsp", TIMEOUT + 100);
        check("timeout_timing", rsp_cyc - take_cyc, TIMEOUT);

        // Reset asserted in the middle of the payload
        push_tx(64'h61_0D_11_22_33_44_0D, 7);
        do_cmd(4'd0, 32'h44332211);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_48mhz);
            #1;
            if (exp_tx.size() == 5) break;
        end
        @(posedge clk_48mhz);
        #2;
        check("pay_tx_valid_before_reset", bus.tx_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        check("abort_tx_valid", bus.tx_valid, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        exp_tx.delete();
        exp_rsp.delete();
        repeat (2) @(negedge clk_48mhz);
        #3 reset_n = 1'b1;

        // SEARCH after the abort
        push_tx(64'h6B_0D, 2);
        push_rsp(3'd0, 32'h0);
        do_cmd(4'd10, 32'h0);
        wait_rsp("search_rsp", 200);
        check("search_tx_drained", exp_tx.size(), 0);

        repeat (3) @(negedge clk_48mhz);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
